ddr_dqs_rcvr_cal_ctrl: RTL and testbench

Sequencer for DQS receiver offset calibration. It drives the receiver into RX-cal mode and sweeps the true-leg and complement-leg calibration codes upward from 0. At each step it samples the receiver outputs through a synchronizer and locks each leg's code at the first step where the majority-voted output flips. It sits between the CSR/training block and the common-config fields of the DQS receiver wrapper (EN, SW_OVR, RXCAL_EN, CAL_*).

---
 rtl/ddr_dqs_rcvr_cal_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ddr_dqs_rcvr_cal_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_dqs_rcvr_cal_ctrl.sv
// DQS receiver offset calibration sequencer: sweeps the true and complement leg
// codes upward and locks each at the first majority-voted output flip.
module ddr_dqs_rcvr_cal_ctrl #(
    parameter int CWIDTH     = 4,
    parameter int SETTLE_CYC = 16,
    parameter int SMP_LOG2   = 3
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_dqs_t,
    input  logic              i_dqs_c,
    output logic              o_rcvr_en,
    output logic              o_rcvr_sw_ovr,
    output logic              o_rxcal_en,
    output logic [CWIDTH-1:0] o_cal_code_t,
    output logic [CWIDTH-1:0] o_cal_code_c,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_aborted,
    output logic              o_err_t,
    output logic              o_err_c
);

    localparam int SAMPLES = 1 << SMP_LOG2;
    localparam int SW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0]       SETTLE_LAST = SW'(SETTLE_CYC - 1);
    localparam logic [SMP_LOG2:0]   SMP_LAST    = (SMP_LOG2 + 1)'(SAMPLES - 1);
    localparam logic [SMP_LOG2:0]   HALF        = (SMP_LOG2 + 1)'(SAMPLES / 2);
    localparam logic [CWIDTH-1:0]   CODE_MAX    = '1;

    typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EVAL, DONE} state_t;

    state_t              state_reg, state_next;
    logic                leg_reg, leg_next;          // 0 = true leg, 1 = complement leg
    logic                first_reg, first_next;
    logic                ref_reg, ref_next;
    logic [SW-1:0]       settle_cnt_reg, settle_cnt_next;
    logic [SMP_LOG2:0]   smp_cnt_reg, smp_cnt_next;
    logic [SMP_LOG2:0]   ones_reg, ones_next;
    logic [CWIDTH-1:0]   code_t_reg, code_t_next;
    logic [CWIDTH-1:0]   code_c_reg, code_c_next;
    logic                err_t_reg, err_t_next;
    logic                err_c_reg, err_c_next;
    logic                active_reg, active_next;
    logic                done_reg, done_next;
    logic                aborted_reg, aborted_next;
    logic [1:0]          sync_t_reg, sync_c_reg;

    logic [CWIDTH-1:0]   code_cur;
    logic                bit_cur;
    logic                vote;
    logic                leg_finish;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            leg_reg        <= 1'b0;
            first_reg      <= 1'b0;
            ref_reg        <= 1'b0;
            settle_cnt_reg <= '0;
            smp_cnt_reg    <= '0;
            ones_reg       <= '0;
            code_t_reg     <= '0;
            code_c_reg     <= '0;
            err_t_reg      <= 1'b0;
            err_c_reg      <= 1'b0;
            active_reg     <= 1'b0;
            done_reg       <= 1'b0;
            aborted_reg    <= 1'b0;
            sync_t_reg     <= '0;
            sync_c_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            leg_reg        <= leg_next;
            first_reg      <= first_next;
            ref_reg        <= ref_next;
            settle_cnt_reg <= settle_cnt_next;
            smp_cnt_reg    <= smp_cnt_next;
            ones_reg       <= ones_next;
            code_t_reg     <= code_t_next;
            code_c_reg     <= code_c_next;
            err_t_reg      <= err_t_next;
            err_c_reg      <= err_c_next;
            active_reg     <= active_next;
            done_reg       <= done_next;
            aborted_reg    <= aborted_next;
            sync_t_reg     <= {sync_t_reg[0], i_dqs_t};
            sync_c_reg     <= {sync_c_reg[0], i_dqs_c};
        end
    end

    always_comb begin
        state_next      = state_reg;
        leg_next        = leg_reg;
        first_next      = first_reg;
        ref_next        = ref_reg;
        settle_cnt_next = settle_cnt_reg;
        smp_cnt_next    = smp_cnt_reg;
        ones_next       = ones_reg;
        code_t_next     = code_t_reg;
        code_c_next     = code_c_reg;
        err_t_next      = err_t_reg;
        err_c_next      = err_c_reg;
        aborted_next    = 1'b0;
        leg_finish      = 1'b0;
        code_cur        = leg_reg ? code_c_reg : code_t_reg;
        bit_cur         = leg_reg ? sync_c_reg[1] : sync_t_reg[1];
        vote            = (ones_reg > HALF);

        // Abort wins over everything so codes and flags keep their last values.
        if (i_abort && state_reg != IDLE) begin
            state_next   = IDLE;
            aborted_next = 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start && !i_abort) begin
                        leg_next        = 1'b0;
                        first_next      = 1'b1;
                        code_t_next     = '0;
                        code_c_next     = '0;
                        err_t_next      = 1'b0;
                        err_c_next      = 1'b0;
                        settle_cnt_next = '0;
                        state_next      = SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        settle_cnt_next = '0;
                        smp_cnt_next    = '0;
                        ones_next       = '0;
                        state_next      = SAMPLE;
                    end else begin
                        settle_cnt_next = settle_cnt_reg + SW'(1);
                    end
                end
                SAMPLE: begin
                    ones_next = ones_reg + {{SMP_LOG2{1'b0}}, bit_cur};
                    if (smp_cnt_reg == SMP_LAST) begin
                        state_next = EVAL;
                    end else begin
                        smp_cnt_next = smp_cnt_reg + (SMP_LOG2 + 1)'(1);
                    end
                end
                EVAL: begin
                    if (first_reg) begin
                        ref_next   = vote;
                        first_next = 1'b0;
                    end
                    if (!first_reg && vote != ref_reg) begin
                        leg_finish = 1'b1;
                    end else if (code_cur != CODE_MAX) begin
                        if (leg_reg) code_c_next = code_c_reg + CWIDTH'(1);
                        else         code_t_next = code_t_reg + CWIDTH'(1);
                        state_next = SETTLE;
                    end else begin
                        if (leg_reg) err_c_next = 1'b1;
                        else         err_t_next = 1'b1;
                        leg_finish = 1'b1;
                    end
                    if (leg_finish) begin
                        if (!leg_reg) begin
                            leg_next   = 1'b1;
                            first_next = 1'b1;
                            state_next = SETTLE;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end

        done_next   = (state_next == DONE);
        active_next = (state_next == SETTLE) || (state_next == SAMPLE) || (state_next == EVAL);
    end

    assign o_rcvr_en     = active_reg;
    assign o_rcvr_sw_ovr = active_reg;
    assign o_rxcal_en    = active_reg;
    assign o_busy        = active_reg;
    assign o_done        = done_reg;
    assign o_aborted     = aborted_reg;
    assign o_cal_code_t  = code_t_reg;
    assign o_cal_code_c  = code_c_reg;
    assign o_err_t       = err_t_reg;
    assign o_err_c       = err_c_reg;

endmodule

// File: tb/tb_ddr_dqs_rcvr_cal_ctrl.sv
// Directed bench for ddr_dqs_rcvr_cal_ctrl with a code-dependent receiver model.
module tb_ddr_dqs_rcvr_cal_ctrl;

    localparam int CW    = 4;
    localparam int LIMIT = 400;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start, abort;
    logic          dqs_t, dqs_c;
    logic          rcvr_en, rcvr_sw_ovr, rxcal_en;
    logic [CW-1:0] code_t, code_c;
    logic          busy, done, aborted, err_t, err_c;

    int            tests  = 0;
    int            failed = 0;
    int            mode   = 0;
    logic [31:0]   cyc    = '0;
    logic          busy_at_done;

    ddr_dqs_rcvr_cal_ctrl #(.CWIDTH(CW), .SETTLE_CYC(4), .SMP_LOG2(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_dqs_t(dqs_t), .i_dqs_c(dqs_c),
        .o_rcvr_en(rcvr_en), .o_rcvr_sw_ovr(rcvr_sw_ovr), .o_rxcal_en(rxcal_en),
        .o_cal_code_t(code_t), .o_cal_code_c(code_c),
        .o_busy(busy), .o_done(done), .o_aborted(aborted),
        .o_err_t(err_t), .o_err_c(err_c)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Receiver model: output level as a function of the applied code.
    always_comb begin
        dqs_t = 1'b0;
        dqs_c = 1'b0;
        case (mode)
            0: begin dqs_t = (code_t >= 4'd6); dqs_c = (code_c < 4'd10); end
            1: begin dqs_t = 1'b1;             dqs_c = (code_c < 4'd3);  end
            2: begin
                if (code_t < 4'd3)       dqs_t = 1'b0;
                else if (code_t == 4'd3) dqs_t = cyc[0];
                else if (code_t == 4'd4) dqs_t = (cyc[1:0] != 2'd3);
                else                     dqs_t = 1'b1;
                dqs_c = (code_c >= 4'd2);
            end
            default: begin dqs_t = (code_t >= 4'd2); dqs_c = 1'b0; end
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outs(input string tag);
        check({tag, "_busy"},    32'(busy),        32'd0);
        check({tag, "_rxcal"},   32'(rxcal_en),    32'd0);
        check({tag, "_en"},      32'(rcvr_en),     32'd0);
        check({tag, "_ovr"},     32'(rcvr_sw_ovr), 32'd0);
        check({tag, "_done"},    32'(done),        32'd0);
        check({tag, "_aborted"}, 32'(aborted),     32'd0);
    endtask

    // Starts a sweep and runs until three cycles past o_done (or LIMIT cycles).
    task automatic run_sweep(input int start_again_at, output int done_at,
                             output int ndone, output int nabort);
        done_at = -1;
        ndone   = 0;
        nabort  = 0;
        start   = 1'b1;
        for (int k = 1; k <= LIMIT; k++) begin
            tick();
            start = (k == start_again_at);
            if (k == 1) check("busy_after_start", 32'(busy), 32'd1);
            if (done) begin
                ndone++;
                if (done_at < 0) begin
                    done_at      = k;
                    busy_at_done = busy;
                end
            end
            if (aborted) nabort++;
            if (done_at >= 0 && k >= done_at + 3) break;
        end
        start = 1'b0;
    endtask

    initial begin
        int done_at, ndone, nabort, cnt;
        bit found;

        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) tick();
        check_idle_outs("reset");
        check("reset_code_t", 32'(code_t), 32'd0);
        check("reset_code_c", 32'(code_c), 32'd0);
        check("reset_err_t",  32'(err_t),  32'd0);
        check("reset_err_c",  32'(err_c),  32'd0);
        rst_n = 1'b1;
        tick();

        // Basic flip, with a start pulse mid-sweep that must be ignored.
        mode = 0;
        run_sweep(50, done_at, ndone, nabort);
        $display("[TB] basic: done_at=%0d code_t=%0d code_c=%0d err=%0d%0d", done_at, code_t, code_c, err_t, err_c);
        check("basic_done_at",  32'(done_at), 32'd163);
        check("basic_ndone",    32'(ndone),   32'd1);
        check("basic_nabort",   32'(nabort),  32'd0);
        check("basic_busy_at_done", 32'(busy_at_done), 32'd0);
        check("basic_code_t",   32'(code_t),  32'd6);
        check("basic_code_c",   32'(code_c),  32'd10);
        check("basic_err_t",    32'(err_t),   32'd0);
        check("basic_err_c",    32'(err_c),   32'd0);
        check_idle_outs("basic_after");

        // start together with abort in IDLE is ignored.
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        $display("[TB] idle start+abort: busy=%0d aborted=%0d code_t=%0d", busy, aborted, code_t);
        check_idle_outs("idle_sa");
        check("idle_sa_code_t", 32'(code_t), 32'd6);
        tick();
        check("idle_sa_busy2",  32'(busy),   32'd0);

        // No flip on the true leg: error and max code, complement leg still runs.
        mode = 1;
        run_sweep(0, done_at, ndone, nabort);
        $display("[TB] noflip: done_at=%0d code_t=%0d code_c=%0d err=%0d%0d", done_at, code_t, code_c, err_t, err_c);
        check("noflip_done_at", 32'(done_at), 32'd181);
        check("noflip_ndone",   32'(ndone),   32'd1);
        check("noflip_code_t",  32'(code_t),  32'd15);
        check("noflip_err_t",   32'(err_t),   32'd1);
        check("noflip_code_c",  32'(code_c),  32'd3);
        check("noflip_err_c",   32'(err_c),   32'd0);

        // Tie gives vote 0 at code 3; 3-of-4 majority locks at code 4.
        mode = 2;
        run_sweep(0, done_at, ndone, nabort);
        $display("[TB] noisy: done_at=%0d code_t=%0d code_c=%0d err=%0d%0d", done_at, code_t, code_c, err_t, err_c);
        check("noisy_done_at", 32'(done_at), 32'd73);
        check("noisy_code_t",  32'(code_t),  32'd4);
        check("noisy_err_t",   32'(err_t),   32'd0);
        check("noisy_code_c",  32'(code_c),  32'd2);

        // Abort during complement-leg SAMPLE at code_c = 7.
        mode  = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            tick();
            if (code_c == 4'd7) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reach_code7", 32'(found), 32'd1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        $display("[TB] abort: aborted=%0d busy=%0d code_t=%0d code_c=%0d", aborted, busy, code_t, code_c);
        check("abort_pulse",  32'(aborted),  32'd1);
        check("abort_busy",   32'(busy),     32'd0);
        check("abort_rxcal",  32'(rxcal_en), 32'd0);
        check("abort_ovr",    32'(rcvr_sw_ovr), 32'd0);
        check("abort_en",     32'(rcvr_en),  32'd0);
        check("abort_code_t", 32'(code_t),   32'd2);
        check("abort_code_c", 32'(code_c),   32'd7);
        check("abort_err_c",  32'(err_c),    32'd0);
        tick();
        check("abort_pulse_end", 32'(aborted), 32'd0);
        cnt = 0;
        repeat (20) begin
            tick();
            if (done) cnt++;
        end
        check("abort_no_done", 32'(cnt), 32'd0);

        // Async reset mid-SETTLE, then a fresh sweep from code 0.
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int k = 0; k < LIMIT; k++) begin
            tick();
            if (code_t == 4'd3) begin
                found = 1'b1;
                break;
            end
        end
        check("rst_reach_code3", 32'(found), 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        $display("[TB] async reset: busy=%0d code_t=%0d code_c=%0d", busy, code_t, code_c);
        check_idle_outs("rst_mid");
        check("rst_mid_code_t", 32'(code_t), 32'd0);
        check("rst_mid_code_c", 32'(code_c), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        run_sweep(0, done_at, ndone, nabort);
        $display("[TB] post-reset: done_at=%0d code_t=%0d code_c=%0d", done_at, code_t, code_c);
        check("post_rst_done_at", 32'(done_at), 32'd163);
        check("post_rst_code_t",  32'(code_t),  32'd6);
        check("post_rst_code_c",  32'(code_c),  32'd10);
        check("post_rst_nabort",  32'(nabort),  32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
